ddr4_cmd_packer: RTL
====================

Name: ddr4_cmd_packer

Overview:
- Registered, parametrised DDR4 command decoder and packer for the SoftMC-DDR4 datapath.
- Accepts one 32-bit SoftMC instruction per cycle over a valid/ready handshake.
- Decodes each instruction into DDR4 pin-level fields (ACT_n, RAS/CAS/WE with row-address overlay, CS_n, bank/BG, address, RdCAS/WrCAS strobes).
- Packs successive commands into the N_SLOTS DFI phase slots of one fabric cycle.
- Executes WAIT instructions as idle NOP cycles; sits between the instruction dispatcher and the DFI/PHY.

Parameters:
- ROW_WIDTH, 17, DFI address width per slot; legal range 15..17.
- BANK_WIDTH, 4, bank-group plus bank bits per slot; legal range 1..4.
- CS_WIDTH, 1, chip selects per slot; legal range 1..4.
- N_SLOTS, 4, DFI phases per fabric clock; legal range 1..8; slot 0 is the earliest phase and occupies the LSBs of every bus.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accepted when in_valid & in_ready.
- instr  in  32  instruction; field layout below.
- dfi_address  out  ROW_WIDTH*N_SLOTS  per-slot address.
- dfi_bank  out  BANK_WIDTH*N_SLOTS  per-slot {BG,BA}.
- dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n  out  N_SLOTS each  per-slot command pins.
- dfi_cs_n  out  CS_WIDTH*N_SLOTS  per-slot chip select.
- mc_rd_cas, mc_wr_cas  out  N_SLOTS each  per-slot read/write CAS strobes.
- bundle_valid  out  1  current DFI bundle carries at least one command.
- busy  out  1  WAIT countdown in progress.
- decode_err  out  1  sticky: an unknown TYPE was seen.

Behaviour:
- Instruction fields:
  - TYPE = instr[31:28]: 4'b1000 = DDR, 4'b1001 = DDR+END, 4'b0001 = WAIT, anything else = illegal.
  - DDR fields: CS_n = instr[24 +: CS_WIDTH], RAS_n = [23], CAS_n = [22], WE_n = [21], bank = instr[17 +: BANK_WIDTH], addr = instr[16:0].
  - WAIT field: count = instr[15:0].
- NOP slot: cs_n, act_n, ras_n, cas_n, we_n all 1; address 0; bank 0; rd/wr_cas 0. No X values are ever driven.
- Slot decode, ACT (RAS_n=0, CAS_n=1, WE_n=1):
  - act_n = 0.
  - ras_n/cas_n/we_n = addr[16]/addr[15]/addr[14].
  - address = addr[13:0], zero-extended to ROW_WIDTH.
- Slot decode, all other DDR commands:
  - act_n = 1; ras/cas/we taken from their fields; address = addr[ROW_WIDTH-1:0].
  - mc_rd_cas = 1 for (1,0,1); mc_wr_cas = 1 for (1,0,0).
- Staging register and slot pointer ptr (0..N_SLOTS-1); each accepted DDR instruction writes slot[ptr].
- Emit condition in cycle t:
  - a DDR accept with ptr==N_SLOTS-1 or TYPE=DDR+END; or
  - no accept while ptr!=0; or
  - a WAIT accept while ptr!=0.
- On emit:
  - At t+1 the outputs show the staging slots, including a slot merged in cycle t; unused slots are NOP.
  - ptr returns to 0 and staging clears to NOP.
- In a cycle with no emit, the outputs show an all-NOP bundle at t+1.
- bundle_valid is registered alongside the bundle: 1 iff the emitted bundle has at least one non-NOP slot.
- Latency:
  - A command that closes a bundle appears 1 cycle after acceptance.
  - No command waits more than 1 cycle after in_valid drops.
- States: FILL (reset state) and WAIT.
  - FILL: in_ready = 1.
  - WAIT accepted in cycle t with count = 0: flush only, stay in FILL.
  - WAIT accepted in cycle t with count = N > 0: enter WAIT at t+1; in_ready = 0 and busy = 1 for exactly N cycles (t+1..t+N); outputs are NOP bundles; return to FILL so the next accept is possible at t+N+1.
  - The counter is 16 bit; count = 16'hFFFF must work without wrap.
- Illegal TYPE: the instruction is accepted and dropped; no slot is consumed; decode_err is set and held until reset. If ptr!=0 this counts as a no-accept cycle, so the partial bundle is flushed.
- Reset (asserted asynchronously, at any time including mid-WAIT or mid-fill):
  - All outputs immediately NOP; bundle_valid, busy and decode_err = 0; ptr = 0; staging cleared; state = FILL.
  - in_ready = 1 from the first clock edge after rst_n deasserts.
  - A command staged but not yet emitted is discarded.

Test Plan:
- N_SLOTS=4; four back-to-back DDR READs, bank 4'h3, addr 0x0040 -> one bundle at t4+1; mc_rd_cas = 4'b1111, act_n = 4'b1111, bundle_valid = 1; the next cycle is an all-NOP bundle with bundle_valid = 0.
- ACT with addr 0x1C123, bank 4'h5, CS_n = 0, then in_valid low -> next cycle slot0 shows act_n = 0, ras/cas/we = 1/1/1, address = 0x0123, bank = 5, cs_n = 0; slots 1..3 are NOP.
- DDR WRITE, then DDR+END PRE -> bundle has slot0 mc_wr_cas = 1 and slot1 PRE (ras = 0, cas = 1, we = 0, act_n = 1); slots 2..3 NOP; 1-cycle latency from the PRE accept.
- Two READs, then WAIT count = 5 -> partial bundle emitted at t+1; in_ready = 0 and busy = 1 for exactly 5 cycles; NOP bundles; the next instruction is accepted on the 6th cycle after the WAIT.
- TYPE = 4'h7 between two READs -> decode_err = 1 and stays 1; the first READ is flushed alone as a partial bundle; the second READ lands in slot0 of a following bundle.
- Assert rst_n = 0 in the middle of WAIT count = 100 with one command staged -> outputs go NOP immediately and busy = 0; after release, in_ready = 1 and the staged command never appears.

Source files
------------

// File: rtl/ddr4_cmd_packer_if.sv
// Instruction handshake and packed DFI bundle between dispatcher, packer and PHY.
// The packer attaches through the slave modport; the dispatcher/observer side uses master.
interface ddr4_cmd_packer_if #(
   parameter int unsigned ROW_WIDTH  = 17,
   parameter int unsigned BANK_WIDTH = 4,
   parameter int unsigned CS_WIDTH   = 1,
   parameter int unsigned N_SLOTS    = 4
) ();

   logic                            in_valid;
   logic                            in_ready;
   logic [31:0]                     instr;
   logic [ROW_WIDTH*N_SLOTS-1:0]    dfi_address;
   logic [BANK_WIDTH*N_SLOTS-1:0]   dfi_bank;
   logic [N_SLOTS-1:0]              dfi_act_n;
   logic [N_SLOTS-1:0]              dfi_ras_n;
   logic [N_SLOTS-1:0]              dfi_cas_n;
   logic [N_SLOTS-1:0]              dfi_we_n;
   logic [CS_WIDTH*N_SLOTS-1:0]     dfi_cs_n;
   logic [N_SLOTS-1:0]              mc_rd_cas;
   logic [N_SLOTS-1:0]              mc_wr_cas;
   logic                            bundle_valid;
   logic                            busy;
   logic                            decode_err;

   modport master (
      output in_valid, instr,
      input  in_ready, dfi_address, dfi_bank, dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
      input  dfi_cs_n, mc_rd_cas, mc_wr_cas, bundle_valid, busy, decode_err
   );

   modport slave (
      input  in_valid, instr,
      output in_ready, dfi_address, dfi_bank, dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
      output dfi_cs_n, mc_rd_cas, mc_wr_cas, bundle_valid, busy, decode_err
   );

endinterface

// File: rtl/ddr4_cmd_packer.sv
// Decodes SoftMC instructions into DDR4 pin fields and packs them into the DFI phase slots
// of one fabric cycle; WAIT instructions become idle NOP cycles.
module ddr4_cmd_packer #(
   parameter int unsigned ROW_WIDTH  = 17,
   parameter int unsigned BANK_WIDTH = 4,
   parameter int unsigned CS_WIDTH   = 1,
   parameter int unsigned N_SLOTS    = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   ddr4_cmd_packer_if.slave    bus_io
);

   localparam int unsigned PtrW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(N_SLOTS - 1);
   localparam int unsigned AddrW = ROW_WIDTH * N_SLOTS;
   localparam int unsigned BankW = BANK_WIDTH * N_SLOTS;
   localparam int unsigned CsW   = CS_WIDTH * N_SLOTS;

   typedef enum logic [0:0] {StFill, StWait} state_e;

   state_e             state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic               err_q, err_d;

   // Staging slots being filled for the next bundle
   logic [AddrW-1:0]   st_addr_q, st_addr_d;
   logic [BankW-1:0]   st_bank_q, st_bank_d;
   logic [CsW-1:0]     st_cs_n_q, st_cs_n_d;
   logic [N_SLOTS-1:0] st_act_n_q, st_act_n_d;
   logic [N_SLOTS-1:0] st_ras_n_q, st_ras_n_d;
   logic [N_SLOTS-1:0] st_cas_n_q, st_cas_n_d;
   logic [N_SLOTS-1:0] st_we_n_q, st_we_n_d;
   logic [N_SLOTS-1:0] st_rd_q, st_rd_d;
   logic [N_SLOTS-1:0] st_wr_q, st_wr_d;

   // Registered DFI bundle
   logic [AddrW-1:0]   out_addr_q, out_addr_d;
   logic [BankW-1:0]   out_bank_q, out_bank_d;
   logic [CsW-1:0]     out_cs_n_q, out_cs_n_d;
   logic [N_SLOTS-1:0] out_act_n_q, out_act_n_d;
   logic [N_SLOTS-1:0] out_ras_n_q, out_ras_n_d;
   logic [N_SLOTS-1:0] out_cas_n_q, out_cas_n_d;
   logic [N_SLOTS-1:0] out_we_n_q, out_we_n_d;
   logic [N_SLOTS-1:0] out_rd_q, out_rd_d;
   logic [N_SLOTS-1:0] out_wr_q, out_wr_d;
   logic               bv_q, bv_d;

   // Merged view: staging plus the slot written this cycle
   logic [AddrW-1:0]   m_addr;
   logic [BankW-1:0]   m_bank;
   logic [CsW-1:0]     m_cs_n;
   logic [N_SLOTS-1:0] m_act_n, m_ras_n, m_cas_n, m_we_n, m_rd, m_wr;
   logic               m_any;

   logic [3:0]            ty;
   logic                  is_ddr, is_end, is_wait;
   logic                  acc, acc_ddr, acc_wait, acc_ill, emit;
   logic [16:0]           raw_addr;
   logic                  raw_ras_n, raw_cas_n, raw_we_n, is_act;
   logic [ROW_WIDTH-1:0]  s_addr;
   logic                  s_act_n, s_ras_n, s_cas_n, s_we_n, s_rd, s_wr;
   logic                  unused_instr;

   assign bus_io.in_ready = (state_q == StFill);
   assign acc             = bus_io.in_valid & bus_io.in_ready;

   assign ty       = bus_io.instr[31:28];
   assign is_ddr   = (ty == 4'b1000) || (ty == 4'b1001);
   assign is_end   = (ty == 4'b1001);
   assign is_wait  = (ty == 4'b0001);
   assign acc_ddr  = acc & is_ddr;
   assign acc_wait = acc & is_wait;
   assign acc_ill  = acc & ~is_ddr & ~is_wait;

   assign raw_addr     = bus_io.instr[16:0];
   assign raw_ras_n    = bus_io.instr[23];
   assign raw_cas_n    = bus_io.instr[22];
   assign raw_we_n     = bus_io.instr[21];
   assign is_act       = ~raw_ras_n & raw_cas_n & raw_we_n;
   assign unused_instr = ^bus_io.instr;

   // ACT carries the upper row bits on RAS/CAS/WE; only 14 bits remain on the address pins
   always_comb begin
      if (is_act) begin
         s_act_n = 1'b0;
         s_ras_n = raw_addr[16];
         s_cas_n = raw_addr[15];
         s_we_n  = raw_addr[14];
         s_addr  = ROW_WIDTH'(raw_addr[13:0]);
         s_rd    = 1'b0;
         s_wr    = 1'b0;
      end else begin
         s_act_n = 1'b1;
         s_ras_n = raw_ras_n;
         s_cas_n = raw_cas_n;
         s_we_n  = raw_we_n;
         s_addr  = raw_addr[ROW_WIDTH-1:0];
         s_rd    = raw_ras_n & ~raw_cas_n & raw_we_n;
         s_wr    = raw_ras_n & ~raw_cas_n & ~raw_we_n;
      end
   end

   always_comb begin
      m_addr  = st_addr_q;
      m_bank  = st_bank_q;
      m_cs_n  = st_cs_n_q;
      m_act_n = st_act_n_q;
      m_ras_n = st_ras_n_q;
      m_cas_n = st_cas_n_q;
      m_we_n  = st_we_n_q;
      m_rd    = st_rd_q;
      m_wr    = st_wr_q;
      if (acc_ddr) begin
         m_addr[ptr_q*ROW_WIDTH +: ROW_WIDTH]  = s_addr;
         m_bank[ptr_q*BANK_WIDTH +: BANK_WIDTH] = bus_io.instr[17 +: BANK_WIDTH];
         m_cs_n[ptr_q*CS_WIDTH +: CS_WIDTH]     = bus_io.instr[24 +: CS_WIDTH];
         m_act_n[ptr_q] = s_act_n;
         m_ras_n[ptr_q] = s_ras_n;
         m_cas_n[ptr_q] = s_cas_n;
         m_we_n[ptr_q]  = s_we_n;
         m_rd[ptr_q]    = s_rd;
         m_wr[ptr_q]    = s_wr;
      end
   end

   // A DDR instruction may itself encode a NOP, so validity is judged per slot content
   always_comb begin
      m_any = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         m_any = m_any | ~(&m_cs_n[i*CS_WIDTH +: CS_WIDTH]) | ~m_act_n[i] | ~m_ras_n[i] |
                 ~m_cas_n[i] | ~m_we_n[i] | (|m_addr[i*ROW_WIDTH +: ROW_WIDTH]) |
                 (|m_bank[i*BANK_WIDTH +: BANK_WIDTH]) | m_rd[i] | m_wr[i];
      end
   end

   // Any cycle that does not add a DDR command closes a partial bundle
   assign emit = (acc_ddr & ((ptr_q == LastPtr) | is_end)) | ((ptr_q != '0) & ~acc_ddr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q | acc_ill;
      unique case (state_q)
         StFill: begin
            if (acc_wait && (bus_io.instr[15:0] != 16'd0)) begin
               state_d = StWait;
               cnt_d   = bus_io.instr[15:0];
            end
         end
         StWait: begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_comb begin
      out_addr_d  = '0;
      out_bank_d  = '0;
      out_cs_n_d  = '1;
      out_act_n_d = '1;
      out_ras_n_d = '1;
      out_cas_n_d = '1;
      out_we_n_d  = '1;
      out_rd_d    = '0;
      out_wr_d    = '0;
      bv_d        = 1'b0;
      st_addr_d   = '0;
      st_bank_d   = '0;
      st_cs_n_d   = '1;
      st_act_n_d  = '1;
      st_ras_n_d  = '1;
      st_cas_n_d  = '1;
      st_we_n_d   = '1;
      st_rd_d     = '0;
      st_wr_d     = '0;
      ptr_d       = '0;
      if (emit) begin
         out_addr_d  = m_addr;
         out_bank_d  = m_bank;
         out_cs_n_d  = m_cs_n;
         out_act_n_d = m_act_n;
         out_ras_n_d = m_ras_n;
         out_cas_n_d = m_cas_n;
         out_we_n_d  = m_we_n;
         out_rd_d    = m_rd;
         out_wr_d    = m_wr;
         bv_d        = m_any;
      end else begin
         st_addr_d  = m_addr;
         st_bank_d  = m_bank;
         st_cs_n_d  = m_cs_n;
         st_act_n_d = m_act_n;
         st_ras_n_d = m_ras_n;
         st_cas_n_d = m_cas_n;
         st_we_n_d  = m_we_n;
         st_rd_d    = m_rd;
         st_wr_d    = m_wr;
         ptr_d      = acc_ddr ? ptr_q + PtrW'(1) : ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFill;
         cnt_q       <= '0;
         ptr_q       <= '0;
         err_q       <= 1'b0;
         st_addr_q   <= '0;
         st_bank_q   <= '0;
         st_cs_n_q   <= '1;
         st_act_n_q  <= '1;
         st_ras_n_q  <= '1;
         st_cas_n_q  <= '1;
         st_we_n_q   <= '1;
         st_rd_q     <= '0;
         st_wr_q     <= '0;
         out_addr_q  <= '0;
         out_bank_q  <= '0;
         out_cs_n_q  <= '1;
         out_act_n_q <= '1;
         out_ras_n_q <= '1;
         out_cas_n_q <= '1;
         out_we_n_q  <= '1;
         out_rd_q    <= '0;
         out_wr_q    <= '0;
         bv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         err_q       <= err_d;
         st_addr_q   <= st_addr_d;
         st_bank_q   <= st_bank_d;
         st_cs_n_q   <= st_cs_n_d;
         st_act_n_q  <= st_act_n_d;
         st_ras_n_q  <= st_ras_n_d;
         st_cas_n_q  <= st_cas_n_d;
         st_we_n_q   <= st_we_n_d;
         st_rd_q     <= st_rd_d;
         st_wr_q     <= st_wr_d;
         out_addr_q  <= out_addr_d;
         out_bank_q  <= out_bank_d;
         out_cs_n_q  <= out_cs_n_d;
         out_act_n_q <= out_act_n_d;
         out_ras_n_q <= out_ras_n_d;
         out_cas_n_q <= out_cas_n_d;
         out_we_n_q  <= out_we_n_d;
         out_rd_q    <= out_rd_d;
         out_wr_q    <= out_wr_d;
         bv_q        <= bv_d;
      end
   end

   assign bus_io.dfi_address  = out_addr_q;
   assign bus_io.dfi_bank     = out_bank_q;
   assign bus_io.dfi_cs_n     = out_cs_n_q;
   assign bus_io.dfi_act_n    = out_act_n_q;
   assign bus_io.dfi_ras_n    = out_ras_n_q;
   assign bus_io.dfi_cas_n    = out_cas_n_q;
   assign bus_io.dfi_we_n     = out_we_n_q;
   assign bus_io.mc_rd_cas    = out_rd_q;
   assign bus_io.mc_wr_cas    = out_wr_q;
   assign bus_io.bundle_valid = bv_q;
   assign bus_io.busy         = (state_q == StWait);
   assign bus_io.decode_err   = err_q;

endmodule
